online_ccm_sched: RTL
=====================

Name: online_ccm_sched

Overview:
- Time-multiplexes one combinational online constant-coefficient multiplier among N requesters, such as the IIR filter taps.
- Arbitration is round-robin. The winner's redundant-digit operand is registered into the CCM input.
- Because the CCM is treated as a multicycle path, the result is captured after a runtime-programmable number of cycles. This lets overclocking experiments sweep the capture latency.
- The captured result is returned tagged with the requester ID.

Parameters:
- STAGE, 4, number of signed digits per operand (2 bits per digit).
- N_REQ, 4, number of requesters (2..8).
- OUT_WL, 22, CCM result width; 2*(STAGE+7) for the 74 coefficient.
- ID_W, 2, requester ID width, equal to clog2(N_REQ).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  per-requester request level
- x_bus  in  N_REQ*2*STAGE  operands; requester i occupies bits [(i+1)*2*STAGE-1 : i*2*STAGE]
- lat_cfg  in  4  capture latency in cycles; 0 is treated as 1
- gnt  out  N_REQ  one-hot, one-cycle acceptance pulse
- ccm_x  out  2*STAGE  registered operand to the CCM
- ccm_y  in  OUT_WL  CCM result
- res_valid  out  1  one-cycle result strobe
- res_id  out  ID_W  requester ID of the result
- res_y  out  OUT_WL  captured result
- res_err  out  1  shadow mismatch flag (see Optional Feature)
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset values: state IDLE; gnt, ccm_x, res_valid, res_id, res_y and res_err all 0; rr_ptr = N_REQ-1, so requester 0 wins first; latency counter 0.
- States: IDLE, WAIT, and CHECK (CHECK exists only with the macro).
- IDLE, at an edge with |req:
  - Winner is the first set req bit searching upward from rr_ptr+1, wrapping around.
  - ccm_x loads the winner's operand slice; the winner index is latched for res_id.
  - rr_ptr loads the winner index.
  - Counter loads max(lat_cfg,1).
  - gnt[winner] is high for exactly the next cycle; state goes to WAIT.
- IDLE with no request: all registers hold; no pulses.
- Requester handshake:
  - Hold req and the operand stable until gnt is seen.
  - Drop req in the gnt cycle.
  - A req still held after gnt is treated as a new request and is served after the other pending requesters.
- WAIT:
  - Counter decrements each edge.
  - At the edge where the counter equals 1: res_y <= ccm_y, res_valid is high for the next cycle, state returns to IDLE.
- Timing:
  - Latency from the acceptance edge to the result-capture edge is exactly L = max(lat_cfg,1) cycles.
  - Throughput is one operation per L+1 cycles, because of the IDLE arbitration cycle.
- lat_cfg is sampled only at acceptance; changes during WAIT are ignored.
- ccm_x, res_y and res_id hold their values between operations. They are not cleared.
- res_valid and gnt are never high in the same cycle.
- busy is high from the cycle after acceptance through the capture edge.
- Asynchronous reset mid-operation:
  - All registers return immediately to their reset values.
  - The in-flight result is discarded; no res_valid is produced.
  - After reset deasserts, arbitration restarts with requester 0 first.
- Width rule: ccm_y is captured unmodified. No truncation and no digit conversion is applied; redundant format is preserved.

Optional Feature:
- Macro: ONLINE_CCM_SHADOW_CHECK_EN.
- Defined:
  - The WAIT capture edge writes ccm_y into res_y and moves to CHECK instead of IDLE. res_valid is not asserted yet.
  - At the CHECK edge, ccm_y is compared with res_y. res_err is set to 1 if they differ, else 0.
  - res_valid then pulses with res_err for the next cycle, and state returns to IDLE.
  - res_y keeps the L-cycle (possibly overclocked) sample.
  - Throughput becomes one operation per L+2 cycles.
- Undefined:
  - CHECK state does not exist.
  - res_err is a constant 0.
  - Timing is exactly as described in Behaviour.

Test Plan:
- Bench CCM model: ccm_y = {14'b0, ccm_x}, zero delay.
- Single request: reset, req=4'b0001, x_bus[7:0]=8'hA5, lat_cfg=3.
  - gnt=4'b0001 for 1 cycle.
  - 3 cycles after acceptance: res_valid=1, res_id=0, res_y=22'h0000A5.
  - busy low afterwards.
- Round-robin: req=4'b1111 held continuously, operands 8'h11/22/33/44, lat_cfg=1.
  - Grants in order 0,1,2,3,0.
  - Results 8'h11, 22, 33, 44 with matching res_id.
  - One result every 2 cycles.
- lat_cfg=0: single request with operand 8'h3C.
  - Behaves exactly as lat_cfg=1; res_y=22'h00003C one cycle after acceptance.
- Latency change in flight: accept with lat_cfg=5, then set lat_cfg=1 during WAIT.
  - Result still appears 5 cycles after acceptance.
- Reset mid-WAIT: accept with lat_cfg=6, pulse rst_n low on cycle 2.
  - No res_valid is produced; all outputs read 0.
  - The next req=4'b0100 is granted immediately.
- With ONLINE_CCM_SHADOW_CHECK_EN:
  - Bench model changes ccm_y by +1 one cycle after capture.
  - Expect res_err=1 with res_valid, and res_y equal to the first sample.
  - With a stable model, res_err=0.

Source files
------------

// File: rtl/online_ccm_sched.sv
// online_ccm_sched
// Shares one combinational online constant-coefficient multiplier (CCM)
// among N_REQ requesters using round-robin arbitration. The winner's
// redundant-digit operand is registered into the CCM input. The CCM output
// is treated as a multicycle path and is captured after a runtime-programmable
// number of cycles (lat_cfg, where 0 means 1). The result is returned tagged
// with the requester ID.
//
// Optional feature macro: ONLINE_CCM_SHADOW_CHECK_EN
//   When defined, a CHECK state follows the capture edge. CHECK resamples
//   ccm_y one cycle later and flags a mismatch on res_err. This exposes
//   captures that were taken too early while overclocking.
//   When undefined, the CHECK state does not exist and res_err is tied to 0.
module online_ccm_sched #(
  parameter int STAGE  = 4,
  parameter int N_REQ  = 4,
  parameter int OUT_WL = 22,
  parameter int ID_W   = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*2*STAGE-1:0] x_bus,
  input  logic [3:0]               lat_cfg,
  output logic [N_REQ-1:0]         gnt,
  output logic [2*STAGE-1:0]       ccm_x,
  input  logic [OUT_WL-1:0]        ccm_y,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [OUT_WL-1:0]        res_y,
  output logic                     res_err,
  output logic                     busy
);

  localparam int XW = 2 * STAGE;

`ifdef ONLINE_CCM_SHADOW_CHECK_EN
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_CHECK = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1
  } state_t;
`endif

  state_t            state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   win_q;
  logic [3:0]        cnt_q;
  logic [XW-1:0]     ccm_x_q;
  logic [N_REQ-1:0]  gnt_q;
  logic              res_valid_q;
  logic [ID_W-1:0]   res_id_q;
  logic [OUT_WL-1:0] res_y_q;

  logic              win_found_d;
  logic [ID_W-1:0]   win_idx_d;
  logic [ID_W-1:0]   cand_d;
  int                cand_int;
  logic [3:0]        lat_eff_d;

  // Per-requester operand slices of the flat operand bus
  logic [XW-1:0] opnd [N_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_opnd
      assign opnd[gi] = x_bus[gi*XW +: XW];
    end
  endgenerate

  // Round-robin search: first set request above rr_ptr, wrapping around
  always_comb begin
    win_found_d = 1'b0;
    win_idx_d   = '0;
    cand_d      = '0;
    cand_int    = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_int = int'(rr_ptr_q) + k;
      if (cand_int >= N_REQ) begin
        cand_int = cand_int - N_REQ;
      end
      cand_d = ID_W'(cand_int);
      if (!win_found_d && req[cand_d]) begin
        win_found_d = 1'b1;
        win_idx_d   = cand_d;
      end
    end
  end

  // A programmed latency of 0 is treated as a single cycle
  assign lat_eff_d = (lat_cfg == 4'd0) ? 4'd1 : lat_cfg;

`ifdef ONLINE_CCM_SHADOW_CHECK_EN
  logic res_err_q;
`endif

  // Scheduler FSM: arbitrate in IDLE, count down the multicycle path in WAIT
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= ID_W'(N_REQ - 1);
      win_q       <= '0;
      cnt_q       <= '0;
      ccm_x_q     <= '0;
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_y_q     <= '0;
`ifdef ONLINE_CCM_SHADOW_CHECK_EN
      res_err_q   <= 1'b0;
`endif
    end else begin
      // Pulses last exactly one cycle
      gnt_q       <= '0;
      res_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (win_found_d) begin
            ccm_x_q  <= opnd[win_idx_d];
            win_q    <= win_idx_d;
            rr_ptr_q <= win_idx_d;
            cnt_q    <= lat_eff_d;
            gnt_q    <= N_REQ'(1) << win_idx_d;
            state_q  <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            // The raw redundant-format result is kept without any conversion
            res_y_q  <= ccm_y;
            res_id_q <= win_q;
`ifdef ONLINE_CCM_SHADOW_CHECK_EN
            state_q  <= S_CHECK;
`else
            res_valid_q <= 1'b1;
            state_q     <= S_IDLE;
`endif
          end
        end
`ifdef ONLINE_CCM_SHADOW_CHECK_EN
        S_CHECK: begin
          // A late sample that differs means the capture was taken too early
          res_err_q   <= (ccm_y != res_y_q);
          res_valid_q <= 1'b1;
          state_q     <= S_IDLE;
        end
`endif
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign ccm_x     = ccm_x_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_y     = res_y_q;
  assign busy      = (state_q != S_IDLE);
`ifdef ONLINE_CCM_SHADOW_CHECK_EN
  assign res_err   = res_err_q;
`else
  assign res_err   = 1'b0;
`endif

endmodule
